alt_cal_e1: RTL

- Upstream phase-error estimator feeding the final-key-length stage.
- Takes raw error and total counts for the test set and computes the fixed-point ratio e1 = err/tot × 2^E1_AMP with a multi-cycle restoring divider.
- Clamps the result into the open interval (0, 2^E1_AMP), so the downstream log2(e1) and log2(1-e1) are always defined.
- Drives the valid/busy/error signals consumed by the key-length stage.

---
 rtl/alt_cal_e1.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/alt_cal_e1.sv
`default_nettype none
// ============================================================================
// Module   : alt_cal_e1
// Purpose  : Phase-error estimator. Computes the fixed-point ratio
//            e1 = err / tot * 2^E1_AMP with a bit-serial restoring divider
//            and clamps it into (0, 2^E1_AMP), so that log2(e1) and
//            log2(1 - e1) downstream are always defined.
// Ports    : clk        - system clock
//            rst        - synchronous active-high reset
//            i_start    - one-cycle start pulse, honoured only in IDLE
//            i_err_cnt  - number of erroneous test bits   [CNT_W]
//            i_tot_cnt  - number of test bits             [CNT_W]
//            o_e1_busy  - computation in progress
//            o_e1       - e1 * 2^E1_AMP, unsigned         [32]
//            o_e1_vld   - one-cycle result strobe
//            o_e1_error - invalid input (tot==0 or err>tot), sticky until
//                         the next accepted start
// Options  : E1_ROUND_EN - when defined, round the quotient to nearest
//            (ties up) before clamping; otherwise truncate.
// Revision : 1.0 - initial release
// ============================================================================
module alt_cal_e1 #(
  parameter int E1_AMP = 24,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_err_cnt,
  input  logic [CNT_W-1:0] i_tot_cnt,
  output logic             o_e1_busy,
  output logic [31:0]      o_e1,
  output logic             o_e1_vld,
  output logic             o_e1_error
);

  // Numerator / quotient width and iteration counter width.
  localparam int c_L    = CNT_W + E1_AMP;
  localparam int c_IW   = $clog2(c_L);
  // 2^E1_AMP at quotient width (+1 guard bit for the rounding increment).
  localparam logic [c_L:0]  c_ONE    = {{c_L{1'b0}}, 1'b1} << E1_AMP;
  localparam logic [31:0]   c_E1_MAX = 32'((64'd1 << E1_AMP) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_DIV   = 3'd2,
    S_FIN   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [CNT_W-1:0]   tot_q, tot_d;
  logic [c_L-1:0]     num_q, num_d;
  logic [c_L-1:0]     quo_q, quo_d;
  logic [CNT_W:0]     rem_q, rem_d;
  logic [c_IW-1:0]    cnt_q, cnt_d;
  logic [31:0]        e1_q, e1_d;
  logic               vld_q, vld_d;
  logic               busy_q, busy_d;
  logic               error_q, error_d;

  // Shifted partial remainder; one extra bit so the compare never wraps.
  logic [CNT_W+1:0]   rem_sh;
  logic               rem_ge;
  logic [c_L:0]       q_fin;

  always_comb begin
    rem_sh = {rem_q, num_q[c_L-1]};
    rem_ge = (rem_sh >= {2'b00, tot_q});

`ifdef E1_ROUND_EN
    // Round to nearest: bump the quotient when the leftover is at least
    // half the divisor (2*rem >= tot).
    q_fin = {1'b0, quo_q} + {{c_L{1'b0}}, ({rem_q, 1'b0} >= {2'b00, tot_q})};
`else
    q_fin = {1'b0, quo_q};
`endif
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    tot_d   = tot_q;
    num_d   = num_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    e1_d    = e1_q;
    vld_d   = 1'b0;
    busy_d  = busy_q;
    error_d = error_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          err_d   = i_err_cnt;
          tot_d   = i_tot_cnt;
          error_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if ((tot_q == '0) || (err_q > tot_q)) begin
          state_d = S_ERR;
        end else begin
          num_d   = {err_q, {E1_AMP{1'b0}}};
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end

      S_DIV: begin
        // One restoring step: bring down the next numerator bit, subtract
        // the divisor if it fits, and record the quotient bit.
        num_d = {num_q[c_L-2:0], 1'b0};
        if (rem_ge) begin
          rem_d = (CNT_W+1)'(rem_sh - {2'b00, tot_q});
        end else begin
          rem_d = rem_sh[CNT_W:0];
        end
        quo_d = {quo_q[c_L-2:0], rem_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == c_IW'(c_L - 1)) begin
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        // Keep e1 strictly inside (0, 1) in fixed point.
        if (q_fin == '0) begin
          e1_d = 32'd1;
        end else if (q_fin >= c_ONE) begin
          e1_d = c_E1_MAX;
        end else begin
          e1_d = 32'(q_fin);
        end
        vld_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      S_ERR: begin
        e1_d    = '0;
        error_d = 1'b1;
        vld_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      err_q   <= '0;
      tot_q   <= '0;
      num_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      e1_q    <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      tot_q   <= tot_d;
      num_q   <= num_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      e1_q    <= e1_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      error_q <= error_d;
    end
  end

  assign o_e1       = e1_q;
  assign o_e1_vld   = vld_q;
  assign o_e1_busy  = busy_q;
  assign o_e1_error = error_q;

endmodule
`default_nettype wire
